// File: rtl/lab5_isa_pkg.sv
// Shared ISA constants for the instruction encoder: opcodes, format codes,
// immediate widths and the loader FSM state encoding.
package lab5_isa_pkg;

    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_R   = 7'b0110011;

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_LD  = 3'd1;
    localparam logic [2:0] FMT_SD  = 3'd2;
    localparam logic [2:0] FMT_BEQ = 3'd3;
    localparam logic [2:0] FMT_JAL = 3'd4;
    localparam logic [2:0] FMT_R   = 3'd5;

    localparam int IMM_W_S = 12;
    localparam int IMM_W_J = 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/lab5_inst_pack.sv
// Purely combinational field packer: decoded fields -> 32-bit RV word.
// Latency 0; no handshake. Also reports whether the format code is legal
// and whether the immediate fits the format's signed range.
module lab5_inst_pack
    import lab5_isa_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_ok_o,
    output logic        fmt_ok_o
);

    // An immediate fits when every bit above its sign bit repeats the sign bit.
    logic fits_s;
    logic fits_j;
    assign fits_s = (&imm_i[31:IMM_W_S-1]) | ~(|imm_i[31:IMM_W_S-1]);
    assign fits_j = (&imm_i[31:IMM_W_J-1]) | ~(|imm_i[31:IMM_W_J-1]);

    // Select the bit layout per format; branch/jump immediates are halfword counts.
    always_comb begin
        word_o     = '0;
        range_ok_o = 1'b1;
        fmt_ok_o   = 1'b1;
        case (fmt_i)
            FMT_I: begin
                word_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
                range_ok_o = fits_s;
            end
            FMT_LD: begin
                word_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LD};
                range_ok_o = fits_s;
            end
            FMT_SD: begin
                word_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_SD};
                range_ok_o = fits_s;
            end
            FMT_BEQ: begin
                word_o     = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                              imm_i[3:0], imm_i[10], OP_BEQ};
                range_ok_o = fits_s;
            end
            FMT_JAL: begin
                word_o     = {imm_i[19], imm_i[9:0], imm_i[10], imm_i[18:11], rd_i, OP_JAL};
                range_ok_o = fits_j;
            end
            FMT_R: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            end
            default: begin
                fmt_ok_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lab5_inst_encoder.sv
// Instruction encoder/loader: packs field bundles and writes them sequentially to imem.
// Latency 1: a transfer at edge N shows mem_we/err_valid during cycle N+1.
// in_ready only in RUN and not during start; rejected bundles are consumed without a write.
module lab5_inst_encoder
    import lab5_isa_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    fmt,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [31:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          err_valid,
    output logic [7:0]    err_count,
    output logic          full,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_vld_q, err_vld_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          full_q, full_d;

    logic [31:0]   word;
    logic          range_ok;
    logic          fmt_ok;
    logic          xfer;

    lab5_inst_pack u_pack (
        .fmt_i      (fmt),
        .rd_i       (rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .funct3_i   (funct3),
        .funct7_i   (funct7),
        .imm_i      (imm),
        .word_o     (word),
        .range_ok_o (range_ok),
        .fmt_ok_o   (fmt_ok)
    );

    // start takes priority, so a coincident bundle is left for the new session.
    assign in_ready = (state_q == S_RUN) && !start;
    assign xfer     = in_valid && in_ready;

    // Next-state: session restart, write of a legal word, or reject accounting.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_vld_d = 1'b0;
        err_cnt_d = err_cnt_q;
        full_d    = full_q;
        if (start) begin
            state_d   = S_RUN;
            wr_ptr_d  = '0;
            err_cnt_d = '0;
            full_d    = 1'b0;
        end else if (xfer) begin
            if (fmt_ok && range_ok) begin
                we_d     = 1'b1;
                addr_d   = wr_ptr_q;
                wdata_d  = word;
                wr_ptr_d = wr_ptr_q + 1'b1;
                // No wrap: the last slot parks the loader until the next start.
                if (wr_ptr_q == LAST_ADDR) begin
                    full_d  = 1'b1;
                    state_d = S_FULL;
                end
            end else begin
                err_vld_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    // State and output registers; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_vld_q <= 1'b0;
            err_cnt_q <= '0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_vld_q <= err_vld_d;
            err_cnt_q <= err_cnt_d;
            full_q    <= full_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err_valid = err_vld_q;
    assign err_count = err_cnt_q;
    assign full      = full_q;
    assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_lab5_inst_encoder.sv
// Self-checking bench for lab5_inst_encoder (DEPTH=4): directed vector table,
// fill/reject/saturation/reset sequences, and random bundles checked by
// decoding each written word back with an immediate generator.
module tb_lab5_inst_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    typedef struct {
        fields_t     f;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          err_valid;
    logic [7:0]    err_count;
    logic          full;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the loader.
    bit m_run  = 0;
    bit m_full = 0;
    int m_ptr  = 0;
    int m_err  = 0;
    int m_addr = 0;
    bit e_we   = 0;
    bit e_err  = 0;

    lab5_inst_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .err_valid (err_valid),
        .err_count (err_count),
        .full      (full),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic fields_t mkf(input logic [2:0] fm, input logic [4:0] d, input logic [4:0] s1,
                                    input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] im);
        fields_t f;
        f.fmt = fm; f.rd = d; f.rs1 = s1; f.rs2 = s2; f.f3 = f3; f.f7 = f7; f.imm = im;
        return f;
    endfunction

    function automatic vec_t mk(input fields_t f, input logic lg, input logic [31:0] w);
        vec_t v;
        v.f = f; v.legal = lg; v.word = w;
        return v;
    endfunction

    // Legality from numeric ranges of the immediate.
    function automatic bit is_legal(input fields_t f);
        int v;
        v = int'(f.imm);
        case (f.fmt)
            3'd0, 3'd1, 3'd2, 3'd3: return (v >= -2048) && (v <= 2047);
            3'd4:                   return (v >= -524288) && (v <= 524287);
            3'd5:                   return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Pipeline-style immediate generator; branch/jump results in halfword units.
    function automatic logic [31:0] imm_gen(input logic [31:0] w);
        logic signed [31:0] t;
        t = '0;
        case (w[6:0])
            7'h13, 7'h03: t = {{20{w[31]}}, w[31:20]};
            7'h23:        t = {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63: begin
                t = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                t = t >>> 1;
            end
            7'h6F: begin
                t = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                t = t >>> 1;
            end
            default: t = '0;
        endcase
        return t;
    endfunction

    // Round-trip: decode the written word and compare every field the format carries.
    task automatic chk_word(input fields_t f, input logic [31:0] w);
        logic [6:0] op;
        bit ok;
        case (f.fmt)
            3'd0: op = 7'h13;
            3'd1: op = 7'h03;
            3'd2: op = 7'h23;
            3'd3: op = 7'h63;
            3'd4: op = 7'h6F;
            default: op = 7'h33;
        endcase
        ok = (w[6:0] == op);
        if (f.fmt != 3'd5)                    ok &= (imm_gen(w) == f.imm);
        if (f.fmt != 3'd2 && f.fmt != 3'd3)   ok &= (w[11:7] == f.rd);
        if (f.fmt != 3'd4)                    ok &= (w[14:12] == f.f3) && (w[19:15] == f.rs1);
        if (f.fmt == 3'd2 || f.fmt == 3'd3 || f.fmt == 3'd5) ok &= (w[24:20] == f.rs2);
        if (f.fmt == 3'd5)                    ok &= (w[31:25] == f.f7);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL roundtrip word=%h fmt=%0d imm=%h decoded_imm=%h", w, f.fmt, f.imm, imm_gen(w));
        end
    endtask

    // One cycle: drive at negedge, predict, check registered outputs at the next negedge.
    task automatic step(input logic st, input logic v, input fields_t f);
        bit exp_rdy;
        start = st; in_valid = v;
        fmt = f.fmt; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
        funct3 = f.f3; funct7 = f.f7; imm = f.imm;
        #1;
        exp_rdy = m_run && !st;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        e_we = 0; e_err = 0;
        if (st) begin
            m_run = 1; m_full = 0; m_ptr = 0; m_err = 0;
        end else if (v && exp_rdy) begin
            if (is_legal(f)) begin
                e_we = 1; m_addr = m_ptr; m_ptr++;
                if (m_ptr == DEPTH) begin m_full = 1; m_run = 0; end
            end else begin
                e_err = 1;
                if (m_err < 255) m_err++;
            end
        end
        @(negedge clk);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("err_valid", 32'(err_valid), 32'(e_err));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("full", 32'(full), 32'(m_full));
        chk("busy", 32'(busy), 32'(m_run));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (e_we) chk_word(f, mem_wdata);
    endtask

    function automatic fields_t rand_fields();
        fields_t f;
        int sel, x;
        sel = int'($urandom_range(0, 99));
        f.fmt = 3'($urandom_range(0, 5));
        f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
        f.f3 = 3'($urandom); f.f7 = 7'($urandom);
        if (f.fmt == 3'd4)      x = int'($urandom_range(0, 1048575)) - 524288;
        else if (f.fmt == 3'd5) x = int'($urandom);
        else                    x = int'($urandom_range(0, 4095)) - 2048;
        if (sel < 5) begin
            f.fmt = 3'($urandom_range(6, 7));
        end else if (sel < 10 && f.fmt != 3'd5) begin
            if (f.fmt == 3'd4) x = ($urandom_range(0, 1) != 0) ? 524288 + int'($urandom_range(0, 99999))
                                                               : -524289 - int'($urandom_range(0, 99999));
            else               x = ($urandom_range(0, 1) != 0) ? 2048 + int'($urandom_range(0, 99999))
                                                               : -2049 - int'($urandom_range(0, 99999));
        end
        f.imm = 32'(x);
        return f;
    endfunction

    vec_t    vec[12];
    fields_t z;
    fields_t lg;
    logic [31:0] last_word;

    initial begin
        z  = mkf(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        lg = mkf(3'd0, 5'd7, 5'd8, 5'd0, 3'd1, 7'd0, 32'd100);
        vec[0]  = mk(mkf(3'd0, 5'd5,  5'd6,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF), 1'b1, 32'hFFF30293);
        vec[1]  = mk(mkf(3'd3, 5'd31, 5'd1,  5'd2,  3'd0, 7'h7F, 32'hFFFFFFFE), 1'b1, 32'hFE208EE3);
        vec[2]  = mk(mkf(3'd4, 5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h0007FFFF), 1'b1, 32'h7FFFF0EF);
        vec[3]  = mk(mkf(3'd2, 5'd0,  5'd2,  5'd3,  3'd3, 7'h00, 32'h00000800), 1'b0, 32'h0);
        vec[4]  = mk(mkf(3'd5, 5'd3,  5'd4,  5'd5,  3'd0, 7'h20, 32'h12345678), 1'b1, 32'h405201B3);
        vec[5]  = mk(mkf(3'd1, 5'd10, 5'd2,  5'd31, 3'd3, 7'h7F, 32'h00000008), 1'b1, 32'h00813503);
        vec[6]  = mk(mkf(3'd2, 5'd31, 5'd2,  5'd10, 3'd3, 7'h7F, 32'hFFFFFFF8), 1'b1, 32'hFEA13C23);
        vec[7]  = mk(mkf(3'd4, 5'd0,  5'd5,  5'd6,  3'd1, 7'h00, 32'hFFF80000), 1'b1, 32'h8000006F);
        vec[8]  = mk(mkf(3'd4, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00080000), 1'b0, 32'h0);
        vec[9]  = mk(mkf(3'd0, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h000007FF), 1'b1, 32'h7FF00093);
        vec[10] = mk(mkf(3'd0, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF7FF), 1'b0, 32'h0);
        vec[11] = mk(mkf(3'd6, 5'd1,  5'd1,  5'd1,  3'd0, 7'h00, 32'h00000000), 1'b0, 32'h0);

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        @(negedge clk); @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst err_valid", 32'(err_valid), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        chk("rst full", 32'(full), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b1, lg);   // IDLE: bundle must not be taken

        // Directed vector table.
        step(1'b1, 1'b0, z);
        last_word = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (m_full) step(1'b1, 1'b0, z);
            step(1'b0, 1'b1, vec[i].f);
            chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vec[i].legal));
            if (vec[i].legal) last_word = vec[i].word;
            chk($sformatf("vec%0d mem_wdata", i), mem_wdata, last_word);
        end

        // Range reject, then the next legal bundle lands at address 0.
        step(1'b1, 1'b0, z);
        step(1'b0, 1'b1, mkf(3'd2, 5'd0, 5'd1, 5'd2, 3'd3, 7'd0, 32'd2048));
        chk("reject err_count", 32'(err_count), 32'd1);
        step(1'b0, 1'b1, lg);
        chk("after reject addr", 32'(mem_addr), 32'd0);

        // Fill: five back-to-back bundles, only four taken.
        step(1'b1, 1'b0, z);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, lg);
            if (i == 3) chk("fill full", 32'(full), 32'd1);
        end
        step(1'b1, 1'b1, lg);   // start wins over a coincident bundle
        step(1'b0, 1'b1, lg);
        chk("resume addr", 32'(mem_addr), 32'd0);

        // Reject counter saturation.
        step(1'b1, 1'b0, z);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, mkf(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
        chk("err_count sat", 32'(err_count), 32'd255);

        // Random bundles with idle gaps and occasional restarts.
        step(1'b1, 1'b0, z);
        for (int i = 0; i < 3000; i++) begin
            if (m_full || $urandom_range(0, 59) == 0)
                step(1'b1, 1'($urandom_range(0, 1)), rand_fields());
            else
                step(1'b0, 1'($urandom_range(0, 3) != 0), rand_fields());
        end

        // Async reset the cycle after a transfer.
        step(1'b1, 1'b0, z);
        step(1'b0, 1'b1, lg);
        chk("pre-reset mem_we", 32'(mem_we), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst mem_we", 32'(mem_we), 32'd0);
        chk("arst mem_addr", 32'(mem_addr), 32'd0);
        chk("arst mem_wdata", mem_wdata, 32'd0);
        chk("arst err_valid", 32'(err_valid), 32'd0);
        chk("arst err_count", 32'(err_count), 32'd0);
        chk("arst full", 32'(full), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd0);
        m_run = 0; m_full = 0; m_ptr = 0; m_err = 0; m_addr = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, lg);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
